msx_mouse_adapter: RTL and testbench

- Per-port MSX general-purpose-port adapter; instantiated once per joystick port.
- Converts host mouse packets into the MSX strobe-clocked nibble protocol, or passes the host joystick through.
- Generalised successor to the single-port inline mouse logic: mode select, configurable timeout, saturating delta accumulation instead of overwrite, and a sensitivity option.
- Sits between user_io mouse/joystick outputs and the emsx_top pJoyA/pJoyB/pStrA/pStrB pins.

---
 rtl/msx_mouse_pkg.sv | 25 ++
 rtl/msx_mouse_acc.sv | 67 ++++++
 rtl/msx_mouse_adapter.sv | 117 +++++++++++
 tb/tb_msx_mouse_adapter.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/msx_mouse_pkg.sv
// rtl/msx_mouse_pkg.sv - shared types and constants for the MSX mouse adapter
package msx_mouse_pkg;

  typedef enum logic [1:0] {
    JOY   = 2'd0,
    MOUSE = 2'd1,
    AUTO  = 2'd2
  } mode_t;

  typedef enum logic [1:0] {
    S0 = 2'd0,
    S1 = 2'd1,
    S2 = 2'd2,
    S3 = 2'd3
  } nib_state_t;

  localparam int SNAP_MAX = 127;
  localparam int SNAP_MIN = -128;

  // The MSX pins carry the nibble bit-reversed relative to the data bits.
  function automatic logic [3:0] nib_rev(input logic [3:0] n);
    return {n[0], n[1], n[2], n[3]};
  endfunction

endpackage

// File: rtl/msx_mouse_acc.sv
// rtl/msx_mouse_acc.sv - one axis of saturating delta accumulator with snapshot
// MSX_MOUSE_SENS_EN adds a sens input that scales the delta by 1/2/4/8.
module msx_mouse_acc
  import msx_mouse_pkg::*;
#(
  parameter int ACC_W = 12
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       add,
  input  logic [9:0] delta,
`ifdef MSX_MOUSE_SENS_EN
  input  logic [1:0] sens,
`endif
  input  logic       snap_en,
  output logic [7:0] clamp_now,
  output logic [7:0] snap
);

  // Headroom so a x8 delta plus the accumulator never wraps before saturation.
  localparam int WW = ACC_W + 6;
  localparam logic signed [WW-1:0] AMAX = WW'((64'sd1 <<< (ACC_W - 1)) - 64'sd1);
  localparam logic signed [WW-1:0] AMIN = -AMAX;
  localparam logic signed [WW-1:0] CMAX = WW'(SNAP_MAX);
  localparam logic signed [WW-1:0] CMIN = WW'(SNAP_MIN);

  logic signed [ACC_W-1:0] acc;
  logic signed [WW-1:0]    acc_w, delta_w, scaled, delta_sat, clamp_w, snap_sub, sum, sum_sat;
  logic                    unused_hi;

  function automatic logic signed [WW-1:0] sat_w(input logic signed [WW-1:0] v);
    if (v > AMAX) return AMAX;
    if (v < AMIN) return AMIN;
    return v;
  endfunction

  always_comb begin
    acc_w   = {{(WW - ACC_W){acc[ACC_W-1]}}, acc};
    delta_w = {{(WW - 10){delta[9]}}, delta};
`ifdef MSX_MOUSE_SENS_EN
    scaled  = delta_w <<< sens;
`else
    scaled  = delta_w;
`endif
    delta_sat = sat_w(scaled);
    if (acc_w > CMAX)      clamp_w = CMAX;
    else if (acc_w < CMIN) clamp_w = CMIN;
    else                   clamp_w = acc_w;
    snap_sub = snap_en ? clamp_w : '0;
    sum      = acc_w - snap_sub + (add ? delta_sat : '0);
    sum_sat  = sat_w(sum);
  end

  assign clamp_now = clamp_w[7:0];
  assign unused_hi = ^{sum_sat[WW-1:ACC_W]};

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      acc  <= '0;
      snap <= '0;
    end else begin
      acc <= sum_sat[ACC_W-1:0];
      if (snap_en) snap <= clamp_w[7:0];
    end
  end

endmodule

// File: rtl/msx_mouse_adapter.sv
// rtl/msx_mouse_adapter.sv - per-port MSX mouse/joystick adapter
// MSX_MOUSE_SENS_EN adds the sens[1:0] delta scaling input.
module msx_mouse_adapter
  import msx_mouse_pkg::*;
#(
  parameter int TIMEOUT = 100000,
  parameter int ACC_W   = 12
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic [1:0] mode,
  input  logic [5:0] joy_n,
  input  logic       mouse_strobe,
  input  logic [7:0] mouse_x,
  input  logic [7:0] mouse_y,
  input  logic [7:0] mouse_flags,
`ifdef MSX_MOUSE_SENS_EN
  input  logic [1:0] sens,
`endif
  input  logic       msx_str,
  output logic [5:0] port_out,
  output logic       mouse_active
);

  localparam int TW = $clog2(TIMEOUT + 1);

  mode_t      mode_m;
  nib_state_t state_q, state_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic       str_d, str_edge, act_d, snap_en, nib_load;
  logic [3:0] nib;
  logic [9:0] dx, dy;
  logic [7:0] clamp_x, clamp_y, snap_x, snap_y;
  logic       unused_bits;

  // MSX counts right as negative, so X is negated; Y passes through.
  assign dx = -{mouse_flags[4], mouse_flags[4], mouse_x};
  assign dy = {mouse_flags[5], mouse_flags[5], mouse_y};
  assign mode_m   = mode_t'(mode);
  assign str_edge = str_d ^ msx_str;
  assign unused_bits = ^{mouse_flags[7:6], mouse_flags[3:2], snap_x[7:4], clamp_x[3:0], clamp_y};

  msx_mouse_acc #(.ACC_W(ACC_W)) u_acc_x (
    .clk_sys(clk_sys), .reset(reset), .add(mouse_strobe), .delta(dx),
`ifdef MSX_MOUSE_SENS_EN
    .sens(sens),
`endif
    .snap_en(snap_en), .clamp_now(clamp_x), .snap(snap_x)
  );

  msx_mouse_acc #(.ACC_W(ACC_W)) u_acc_y (
    .clk_sys(clk_sys), .reset(reset), .add(mouse_strobe), .delta(dy),
`ifdef MSX_MOUSE_SENS_EN
    .sens(sens),
`endif
    .snap_en(snap_en), .clamp_now(clamp_y), .snap(snap_y)
  );

  always_comb begin
    case (mode_m)
      JOY:     act_d = 1'b0;
      MOUSE:   act_d = 1'b1;
      default: begin
        // A joystick press beats a simultaneous mouse packet.
        if (joy_n != 6'h3F)    act_d = 1'b0;
        else if (mouse_strobe) act_d = 1'b1;
        else                   act_d = mouse_active;
      end
    endcase
  end

  always_comb begin
    state_d  = state_q;
    tmo_d    = tmo_q;
    snap_en  = 1'b0;
    nib_load = 1'b0;
    nib      = 4'h0;
    if (!mouse_active) begin
      state_d = S0;
      tmo_d   = '0;
    end else if (str_edge) begin
      tmo_d    = TW'(TIMEOUT);
      nib_load = 1'b1;
      case (state_q)
        S0: begin snap_en = 1'b1; nib = clamp_x[7:4]; state_d = S1; end
        S1: begin nib = snap_x[3:0]; state_d = S2; end
        S2: begin nib = snap_y[7:4]; state_d = S3; end
        default: begin nib = snap_y[3:0]; state_d = S0; end
      endcase
    end else if (tmo_q != '0) begin
      tmo_d = tmo_q - 1'b1;
      if (tmo_q == TW'(1)) state_d = S0;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q      <= S0;
      tmo_q        <= '0;
      str_d        <= 1'b0;
      mouse_active <= 1'b0;
      port_out     <= 6'h3F;
    end else begin
      state_q      <= state_d;
      tmo_q        <= tmo_d;
      str_d        <= msx_str;
      mouse_active <= act_d;
      if (!mouse_active) begin
        port_out <= joy_n | {6{msx_str}};
      end else begin
        port_out[5:4] <= ~mouse_flags[1:0];
        if (nib_load) port_out[3:0] <= nib_rev(nib);
      end
    end
  end

endmodule

// File: tb/tb_msx_mouse_adapter.sv
// tb/tb_msx_mouse_adapter.sv - directed scoreboard bench for msx_mouse_adapter
module tb_msx_mouse_adapter;

  localparam int TMO  = 20;
  localparam int AMAX = 2047;

  logic       clk_sys = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] mode = 2'd0;
  logic [5:0] joy_n = 6'h3F;
  logic       mouse_strobe = 1'b0;
  logic [7:0] mouse_x = 8'h00, mouse_y = 8'h00, mouse_flags = 8'h00;
  logic       msx_str = 1'b0;
  logic [5:0] port_out;
  logic       mouse_active;

  int errors = 0, checks = 0;
  int ax = 0, ay = 0, st = 0;
  logic [1:0] btn = 2'b00;
  logic [7:0] sx = 8'h00, sy = 8'h00;
  logic [5:0] sb[$];
  logic [5:0] last_exp = 6'h00;

  msx_mouse_adapter #(.TIMEOUT(TMO), .ACC_W(12)) dut (
    .clk_sys(clk_sys), .reset(reset), .mode(mode), .joy_n(joy_n),
    .mouse_strobe(mouse_strobe), .mouse_x(mouse_x), .mouse_y(mouse_y),
    .mouse_flags(mouse_flags),
`ifdef MSX_MOUSE_SENS_EN
    .sens(2'b00),
`endif
    .msx_str(msx_str), .port_out(port_out), .mouse_active(mouse_active)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic check(input string tag, input logic [5:0] obs, input logic [5:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int v);
    if (v > AMAX) return AMAX;
    if (v < -AMAX) return -AMAX;
    return v;
  endfunction

  function automatic logic [7:0] clamp8(input int v);
    int c;
    c = (v > 127) ? 127 : ((v < -128) ? -128 : v);
    return c[7:0];
  endfunction

  function automatic logic [3:0] rev4(input logic [3:0] n);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = n[3-i];
    return r;
  endfunction

  task automatic model_edge(output logic [5:0] e);
    logic [3:0] nib;
    case (st)
      0: begin
        sx = clamp8(ax);
        sy = clamp8(ay);
        ax = ax - int'($signed(sx));
        ay = ay - int'($signed(sy));
        nib = sx[7:4];
      end
      1: nib = sx[3:0];
      2: nib = sy[7:4];
      default: nib = sy[3:0];
    endcase
    st = (st + 1) % 4;
    e = {~btn, rev4(nib)};
  endtask

  task automatic read_nib(input string tag);
    logic [5:0] e, got;
    msx_str = ~msx_str;
    model_edge(e);
    sb.push_back(e);
    tick();
    got = sb.pop_front();
    check(tag, port_out, got);
    last_exp = got;
  endtask

  task automatic send(input logic [7:0] x, input logic [7:0] y, input logic xs, input logic ys,
                      input logic [1:0] b, input logic with_edge, input string tag);
    int dx, dy;
    logic [5:0] e, got;
    dx = xs ? int'(x) - 256 : int'(x);
    dx = -dx;
    dy = ys ? int'(y) - 256 : int'(y);
    mouse_x = x;
    mouse_y = y;
    mouse_flags = {2'b00, ys, xs, 2'b00, b};
    mouse_strobe = 1'b1;
    btn = b;
    if (with_edge) begin
      msx_str = ~msx_str;
      model_edge(e);
      sb.push_back(e);
    end
    ax = sat(ax + dx);
    ay = sat(ay + dy);
    tick();
    mouse_strobe = 1'b0;
    if (with_edge) begin
      got = sb.pop_front();
      check(tag, port_out, got);
      last_exp = got;
    end
  endtask

  initial begin
    repeat (3) tick();
    check("reset_port", port_out, 6'h3F);
    check("reset_active", {5'b0, mouse_active}, 6'h00);

    reset = 1'b0;
    joy_n = 6'h3E;
    tick();
    check("joy_pass", port_out, 6'h3E);
    msx_str = 1'b1;
    tick();
    check("joy_str_high", port_out, 6'h3F);
    msx_str = 1'b0;
    joy_n = 6'h3F;
    tick();
    mode = 2'd1;
    tick();
    check("mode1_active", {5'b0, mouse_active}, 6'h01);

    send(8'h05, 8'h03, 1'b0, 1'b0, 2'b00, 1'b0, "basic_pkt");
    for (int i = 0; i < 4; i++) read_nib($sformatf("basic_nib%0d", i));
    for (int i = 0; i < 4; i++) read_nib($sformatf("basic_zero%0d", i));

    for (int i = 0; i < 3; i++) send(8'd100, 8'h00, 1'b0, 1'b0, 2'b01, 1'b0, "sat_pkt");
    for (int i = 0; i < 12; i++) read_nib($sformatf("sat_nib%0d", i));

    send(8'd7, 8'h00, 1'b0, 1'b0, 2'b10, 1'b0, "tmo_pkt0");
    read_nib("tmo_a");
    read_nib("tmo_b");
    send(8'd9, 8'h00, 1'b0, 1'b0, 2'b10, 1'b0, "tmo_pkt1");
    repeat (TMO + 1) tick();
    check("tmo_hold", port_out, last_exp);
    st = 0;
    for (int i = 0; i < 4; i++) read_nib($sformatf("tmo_nib%0d", i));

    send(8'd10, 8'h00, 1'b0, 1'b0, 2'b11, 1'b0, "sim_pre");
    send(8'hFD, 8'h00, 1'b1, 1'b0, 2'b11, 1'b1, "sim_edge");
    for (int i = 0; i < 7; i++) read_nib($sformatf("sim_nib%0d", i));

    mode = 2'd0;
    tick();
    st = 0;
    mode = 2'd2;
    tick();
    check("auto_idle", {5'b0, mouse_active}, 6'h00);
    send(8'd1, 8'h00, 1'b0, 1'b0, 2'b00, 1'b0, "auto_pkt");
    check("auto_set", {5'b0, mouse_active}, 6'h01);
    joy_n = 6'h2F;
    tick();
    check("auto_clear", {5'b0, mouse_active}, 6'h00);
    tick();
    check("auto_joy", port_out, 6'h2F | {6{msx_str}});
    joy_n = 6'h3F;
    tick();
    joy_n = 6'h2F;
    send(8'd1, 8'h00, 1'b0, 1'b0, 2'b00, 1'b0, "auto_both_pkt");
    check("auto_both", {5'b0, mouse_active}, 6'h00);
    joy_n = 6'h3F;

    mode = 2'd1;
    tick();
    tick();
    st = 0;
    send(8'd7, 8'h00, 1'b0, 1'b0, 2'b01, 1'b0, "rst_pkt");
    read_nib("rst_pre");
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    ax = 0;
    ay = 0;
    st = 0;
    tick();
    for (int i = 0; i < 4; i++) read_nib($sformatf("rst_nib%0d", i));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
